// File: rtl/t07_mem_arbiter_pkg.sv
// Shared types and encodings for the two-requester memory port arbiter.
package t07_mem_arb_pkg;

    // Arbiter sequencing: sample, drive for one cycle, wait for busy to fall, acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_t;

    // External mem_rwi encodings; 2'b11 is never driven.
    localparam logic [1:0] RWI_IDLE  = 2'b00;
    localparam logic [1:0] RWI_READ  = 2'b01;
    localparam logic [1:0] RWI_WRITE = 2'b10;

    // Bus command for a granted transaction: stores write, fetches and loads read.
    function automatic logic [1:0] rwi_for(input logic we);
        return we ? RWI_WRITE : RWI_READ;
    endfunction

endpackage

// File: rtl/t07_mem_arbiter_if.sv
// Requester and external-memory signals seen by the arbiter.
//
// Handshake: a requester raises *_req together with its address (and, for
// data, d_we/d_wdata) and holds *_req until it sees the one-cycle *_ack.
// The arbiter latches the request fields on grant, so later changes are
// ignored until the next grant. *_rdata is valid in the *_ack cycle and
// stays registered afterwards. On the memory side the arbiter drives
// mem_rwi/mem_addr/mem_wdata and treats a falling edge of mem_busy as
// completion, with mem_rdata sampled on that edge.
interface t07_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_rwi;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;

    // Arbiter view: serves the requesters and owns the external bus.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rwi
    );

    // Requester / memory view: everything the arbiter does not drive.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rwi
    );

endinterface

// File: rtl/t07_edge_detect.sv
// Registers mem_busy and flags its falling edge; clearable so that a stale
// busy level from a previous transaction cannot fake a completion.
module t07_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    input  logic i_clr,
    output logic o_fall
);

    logic r_busy_q;

    // Busy history register; forced low on clear so a rise must be seen first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_q <= 1'b0;
        end else if (i_clr) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= i_busy;
        end
    end

    assign o_fall = r_busy_q & ~i_busy;

endmodule

// File: rtl/t07_mem_arbiter.sv
// Shares one external memory port between instruction fetch and data
// load/store. Data has fixed priority; each transaction is latched on grant,
// driven until busy falls (or a timeout expires) and acknowledged once.
module t07_mem_arbiter
    import t07_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    t07_mem_arbiter_if.slave  bus,
    output logic              freeze,
    output logic              timeout_err,
    output state_t            o_dbg_state
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t            r_state;
    req_t              r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_timeout_err;

    state_t            w_state_nxt;
    req_t              w_gnt_sel;
    logic              w_grant;
    logic              w_complete;
    logic              w_timeout;
    logic              w_clr;
    logic              w_fall;
    logic [7:0]        w_cnt_nxt;
    logic [1:0]        w_rwi;
    logic              w_if_ack;
    logic              w_d_ack;

    t07_edge_detect u_busy_edge (
        .clk    (clk),
        .rst_n  (nrst),
        .i_busy (bus.mem_busy),
        .i_clr  (w_clr),
        .o_fall (w_fall)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, bus command and ack pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_sel   = r_gnt;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_clr       = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_rwi       = RWI_IDLE;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_req) begin
                    w_grant     = 1'b1;
                    w_gnt_sel   = REQ_DATA;
                    w_state_nxt = ISSUE;
                end else if (bus.if_req) begin
                    w_grant     = 1'b1;
                    w_gnt_sel   = REQ_FETCH;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_rwi       = rwi_for(r_we);
                w_clr       = 1'b1;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_rwi = rwi_for(r_we);
                if (w_fall) begin
                    w_complete  = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt + 8'd1 == LP_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            DONE: begin
                w_if_ack    = (r_gnt == REQ_FETCH);
                w_d_ack     = (r_gnt == REQ_DATA);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transaction latch, wait counter, read-data capture and sticky timeout flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_gnt         <= REQ_FETCH;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= 8'd0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_grant) begin
                r_gnt <= w_gnt_sel;
                if (w_gnt_sel == REQ_DATA) begin
                    r_we    <= bus.d_we;
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= bus.if_addr;
                    r_wdata <= '0;
                end
            end
            if (w_complete) begin
                if (r_gnt == REQ_FETCH) begin
                    r_if_rdata <= bus.mem_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= bus.mem_rdata;
                end
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                if (r_gnt == REQ_FETCH) begin
                    r_if_rdata <= '0;
                end else if (!r_we) begin
                    r_d_rdata <= '0;
                end
            end
        end
    end

    assign bus.mem_rwi   = w_rwi;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = w_if_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    // The data requester is released in its own ack cycle so the PC can advance.
    assign freeze      = bus.d_req & ~((r_state == DONE) && (r_gnt == REQ_DATA));
    assign timeout_err = r_timeout_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Directed bench for t07_mem_arbiter: fetch, store, simultaneous requests,
// timeout, reset mid-transaction and address change after grant.
module tb_t07_mem_arbiter;
    import t07_mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    t07_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic   freeze;
    logic   timeout_err;
    state_t dbg_state;

    t07_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) u_dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus),
        .freeze      (freeze),
        .timeout_err (timeout_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    int n_if_ack = 0;
    int n_d_ack  = 0;

    // Ack pulses counted at the edge that ends their cycle.
    always @(posedge clk) begin
        if (bus.if_ack) n_if_ack <= n_if_ack + 1;
        if (bus.d_ack)  n_d_ack  <= n_d_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mem_respond(input logic [31:0] rdata);
        bus.mem_busy  = 1'b0;
        bus.mem_rdata = rdata;
        exp_q.push_back(rdata);
    endtask

    initial begin
        nrst         = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_busy = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_rwi", 32'(bus.mem_rwi), 32'(RWI_IDLE));
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_ack", 32'(bus.if_ack), 32'h0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        nrst = 1'b1;
        cyc(1);

        // 1: fetch only
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        cyc(1);
        chk("t1_state_issue", 32'(dbg_state), 32'(ISSUE));
        chk("t1_rwi", 32'(bus.mem_rwi), 32'(RWI_READ));
        chk("t1_addr", bus.mem_addr, 32'h40);
        chk("t1_freeze", 32'(freeze), 32'h0);
        bus.mem_busy = 1'b1;
        cyc(1);
        chk("t1_state_wait", 32'(dbg_state), 32'(WAIT));
        chk("t1_rwi_wait", 32'(bus.mem_rwi), 32'(RWI_READ));
        cyc(2);
        chk("t1_no_ack_busy", 32'(bus.if_ack), 32'h0);
        mem_respond(32'h0051_3093);
        cyc(1);
        chk("t1_if_ack", 32'(bus.if_ack), 32'h1);
        chk("t1_d_ack", 32'(bus.d_ack), 32'h0);
        chk("t1_if_rdata", bus.if_rdata, exp_q.pop_front());
        chk("t1_rwi_done", 32'(bus.mem_rwi), 32'(RWI_IDLE));
        chk("t1_freeze_done", 32'(freeze), 32'h0);
        bus.if_req = 1'b0;
        cyc(1);
        chk("t1_ack_low", 32'(bus.if_ack), 32'h0);
        chk("t1_idle", 32'(dbg_state), 32'(IDLE));

        // 2: store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h3300_0010;
        bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_freeze_req", 32'(freeze), 32'h1);
        cyc(1);
        chk("t2_rwi", 32'(bus.mem_rwi), 32'(RWI_WRITE));
        chk("t2_addr", bus.mem_addr, 32'h3300_0010);
        chk("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_freeze_issue", 32'(freeze), 32'h1);
        bus.mem_busy  = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        cyc(1);
        bus.d_wdata = 32'h0;
        chk("t2_freeze_wait", 32'(freeze), 32'h1);
        cyc(2);
        chk("t2_wdata_held", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_no_ack_busy", 32'(bus.d_ack), 32'h0);
        bus.mem_busy = 1'b0;
        cyc(1);
        chk("t2_d_ack", 32'(bus.d_ack), 32'h1);
        chk("t2_if_ack", 32'(bus.if_ack), 32'h0);
        chk("t2_freeze_ack", 32'(freeze), 32'h0);
        chk("t2_d_rdata_kept", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        cyc(1);
        chk("t2_ack_low", 32'(bus.d_ack), 32'h0);
        chk("t2_freeze_low", 32'(freeze), 32'h0);

        // 3: simultaneous fetch and load
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0100;
        cyc(1);
        chk("t3_data_rwi", 32'(bus.mem_rwi), 32'(RWI_READ));
        chk("t3_data_addr", bus.mem_addr, 32'h100);
        chk("t3_freeze", 32'(freeze), 32'h1);
        bus.mem_busy = 1'b1;
        cyc(3);
        mem_respond(32'hCAFE_0001);
        cyc(1);
        chk("t3_d_ack", 32'(bus.d_ack), 32'h1);
        chk("t3_if_ack_not_yet", 32'(bus.if_ack), 32'h0);
        chk("t3_d_rdata", bus.d_rdata, exp_q.pop_front());
        bus.d_req = 1'b0;
        cyc(1);
        chk("t3_idle_between", 32'(dbg_state), 32'(IDLE));
        cyc(1);
        chk("t3_fetch_rwi", 32'(bus.mem_rwi), 32'(RWI_READ));
        chk("t3_fetch_addr", bus.mem_addr, 32'h200);
        bus.mem_busy = 1'b1;
        cyc(3);
        mem_respond(32'h0000_A0B7);
        cyc(1);
        chk("t3_if_ack", 32'(bus.if_ack), 32'h1);
        chk("t3_d_ack_once", 32'(bus.d_ack), 32'h0);
        chk("t3_if_rdata", bus.if_rdata, exp_q.pop_front());
        bus.if_req = 1'b0;
        cyc(1);
        chk("t3_if_ack_count", 32'(n_if_ack), 32'd2);
        chk("t3_d_ack_count", 32'(n_d_ack), 32'd2);

        // 4: timeout with TIMEOUT = 8
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0044;
        cyc(1);
        bus.mem_busy = 1'b1;
        cyc(8);
        chk("t4_last_wait", 32'(dbg_state), 32'(WAIT));
        chk("t4_no_ack_yet", 32'(bus.d_ack), 32'h0);
        chk("t4_terr_before", 32'(timeout_err), 32'h0);
        cyc(1);
        exp_q.push_back(32'h0);
        chk("t4_d_ack", 32'(bus.d_ack), 32'h1);
        chk("t4_d_rdata_zero", bus.d_rdata, exp_q.pop_front());
        chk("t4_terr_set", 32'(timeout_err), 32'h1);
        chk("t4_rwi_idle", 32'(bus.mem_rwi), 32'(RWI_IDLE));
        bus.d_req    = 1'b0;
        bus.mem_busy = 1'b0;
        cyc(1);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        cyc(1);
        bus.mem_busy = 1'b1;
        cyc(3);
        mem_respond(32'h1111_1111);
        cyc(1);
        chk("t4_good_if_ack", 32'(bus.if_ack), 32'h1);
        chk("t4_good_rdata", bus.if_rdata, exp_q.pop_front());
        chk("t4_terr_sticky", 32'(timeout_err), 32'h1);
        bus.if_req = 1'b0;
        cyc(1);

        // 5: reset in the middle of a store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0500;
        bus.d_wdata = 32'h55AA_55AA;
        cyc(1);
        bus.mem_busy = 1'b1;
        cyc(1);
        chk("t5_rwi_write", 32'(bus.mem_rwi), 32'(RWI_WRITE));
        nrst = 1'b0;
        #1;
        chk("t5_rwi_async", 32'(bus.mem_rwi), 32'(RWI_IDLE));
        chk("t5_state_async", 32'(dbg_state), 32'(IDLE));
        chk("t5_d_ack", 32'(bus.d_ack), 32'h0);
        chk("t5_if_ack", 32'(bus.if_ack), 32'h0);
        chk("t5_terr_clear", 32'(timeout_err), 32'h0);
        cyc(1);
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.mem_busy = 1'b0;
        nrst         = 1'b1;
        cyc(1);
        chk("t5_idle_after", 32'(dbg_state), 32'(IDLE));
        chk("t5_no_ack", 32'(bus.d_ack), 32'h0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0600;
        cyc(1);
        chk("t5_fetch_addr", bus.mem_addr, 32'h600);
        bus.mem_busy = 1'b1;
        cyc(3);
        mem_respond(32'h600D_F00D);
        cyc(1);
        chk("t5_if_ack", 32'(bus.if_ack), 32'h1);
        chk("t5_if_rdata", bus.if_rdata, exp_q.pop_front());
        bus.if_req = 1'b0;
        cyc(1);

        // 6: address change after grant
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        cyc(1);
        chk("t6_addr_issue", bus.mem_addr, 32'h40);
        bus.mem_busy = 1'b1;
        cyc(1);
        bus.if_addr = 32'h0000_0080;
        #1;
        chk("t6_addr_wait", bus.mem_addr, 32'h40);
        cyc(2);
        chk("t6_addr_wait2", bus.mem_addr, 32'h40);
        mem_respond(32'h0000_0013);
        cyc(1);
        chk("t6_addr_done", bus.mem_addr, 32'h40);
        chk("t6_if_ack", 32'(bus.if_ack), 32'h1);
        chk("t6_if_rdata", bus.if_rdata, exp_q.pop_front());
        bus.if_req = 1'b0;
        cyc(1);

        // ack totals: one per served request, none for the reset store
        chk("end_if_ack_count", 32'(n_if_ack), 32'd5);
        chk("end_d_ack_count", 32'(n_d_ack), 32'd3);
        chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
